// File: rtl/rvfi_trace_pkg.sv
// Shared RVFI trace types for the shadow trace pipeline: captured record,
// snooped memory fields and the full commit packet.
package rvfi_trace_pkg;

    localparam logic [6:0] OPC_NONE = 7'b000_0000;

    typedef struct packed {
        logic [31:0] pc_rdata;
        logic [31:0] inst;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
    } rec_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] rdata;
        logic [31:0] wdata;
    } mem_t;

    localparam mem_t MEM_NONE = '0;

    typedef struct packed {
        rec_t        rec;
        mem_t        mem;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] pc_wdata;
        logic        trap;
    } pkt_t;

    // An all-zero opcode field is never a legal encoding, so it retires as a trap.
    function automatic logic is_trap(input logic [31:0] inst);
        return inst[6:0] == OPC_NONE;
    endfunction

endpackage

// File: rtl/rvfi_stage_slot.sv
// One shadow-pipeline stage: valid bit plus trace record and memory fields,
// with hold, load, bubble, flush and the memory-field patch for the mem stage.
module rvfi_stage_slot
    import rvfi_trace_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic in_valid_i,
    input  rec_t in_rec_i,
    input  mem_t in_mem_i,
    input  logic stall_i,
    input  logic flush_i,
    input  logic patch_en_i,
    input  logic patch_valid_i,
    input  mem_t patch_mem_i,
    output logic live_o,
    output rec_t rec_o,
    output mem_t mem_o
);

    logic valid_q;
    logic valid_d;
    rec_t rec_q;
    mem_t mem_q;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        valid_d = valid_q;
        if (!stall_i) begin
            valid_d = in_valid_i;
        end
        if (flush_i) begin
            valid_d = 1'b0;
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only, so all flops sample pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // NOTE: payload registers are deliberately not reset; the valid bit alone qualifies them.
    always_ff @(posedge clk) begin
        if (!stall_i) begin
            rec_q <= in_rec_i;
            mem_q <= in_mem_i;
        end
    end

    // A flushed record is dead this cycle: it neither moves on nor counts as a younger pc source.
    assign live_o = valid_q & ~flush_i;
    assign rec_o  = rec_q;

    // The mem-stage slot forwards the snooped fields, so they land in the next stage as the record leaves.
    assign mem_o = !patch_en_i   ? mem_q       :
                   patch_valid_i ? patch_mem_i : MEM_NONE;

endmodule

// File: rtl/rvfi_shadow_pipe.sv
// RVFI shadow trace pipeline: DEPTH stage slots, pc_wdata priority mux, order counter and halt flag.
// Optional perf counters are built when RVFI_PERF_CNT_EN is defined.
module rvfi_shadow_pipe
    import rvfi_trace_pkg::*;
#(
    parameter int DEPTH     = 3,
    parameter int MEM_STAGE = 1,
    parameter int ORDER_W   = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cap_valid,
    input  rec_t               cap_rec,
    input  logic [DEPTH-1:0]   stall,
    input  logic [DEPTH-1:0]   flush,
    input  logic               mem_valid,
    input  mem_t               mem_rec,
    input  logic [31:0]        fetch_pc,
    input  logic               wb_load_rf,
    input  logic [4:0]         wb_rd_addr,
    input  logic [31:0]        wb_rd_wdata,
    output logic               rvfi_commit,
    output pkt_t               rvfi_pkt,
    output logic [ORDER_W-1:0] rvfi_order,
    output logic               rvfi_halt,
    output logic [31:0]        perf_commits,
    output logic [31:0]        perf_bubbles
);

    logic [DEPTH-1:0] live;
    logic [DEPTH-1:0] in_valid;
    rec_t             in_rec    [DEPTH];
    mem_t             in_mem    [DEPTH];
    rec_t             stage_rec [DEPTH];
    mem_t             stage_mem [DEPTH];
    logic [31:0]      pc_wdata;
    logic [ORDER_W-1:0] order_q;

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        if (g == 0) begin : g_head
            assign in_valid[g] = cap_valid;
            assign in_rec[g]   = cap_rec;
            assign in_mem[g]   = MEM_NONE;
        end else begin : g_tail
            // A stalled predecessor hands a bubble to a moving successor.
            assign in_valid[g] = live[g-1] & ~stall[g-1];
            assign in_rec[g]   = stage_rec[g-1];
            assign in_mem[g]   = stage_mem[g-1];
        end

        rvfi_stage_slot u_slot (
            .clk          (clk),
            .rst          (rst),
            .in_valid_i   (in_valid[g]),
            .in_rec_i     (in_rec[g]),
            .in_mem_i     (in_mem[g]),
            .stall_i      (stall[g]),
            .flush_i      (flush[g]),
            .patch_en_i   (g == MEM_STAGE),
            .patch_valid_i(mem_valid),
            .patch_mem_i  (mem_rec),
            .live_o       (live[g]),
            .rec_o        (stage_rec[g]),
            .mem_o        (stage_mem[g])
        );
    end

    // Next pc is the nearest younger live record; later loop iterations win.
    always_comb begin
        pc_wdata = fetch_pc;
        for (int i = 0; i < DEPTH - 1; i++) begin
            if (live[i]) begin
                pc_wdata = stage_rec[i].pc_rdata;
            end
        end
    end

    assign rvfi_commit = live[DEPTH-1] & ~stall[DEPTH-1] & ~rst;

    always_comb begin
        rvfi_pkt          = '0;
        rvfi_pkt.rec      = stage_rec[DEPTH-1];
        rvfi_pkt.mem      = stage_mem[DEPTH-1];
        rvfi_pkt.rd_addr  = wb_load_rf ? wb_rd_addr : 5'd0;
        rvfi_pkt.rd_wdata = (wb_load_rf && wb_rd_addr != 5'd0) ? wb_rd_wdata : 32'd0;
        rvfi_pkt.pc_wdata = pc_wdata;
        rvfi_pkt.trap     = is_trap(stage_rec[DEPTH-1].inst);
    end

    // A jump-to-self at a non-zero pc is the core's halt idiom.
    assign rvfi_halt = rvfi_commit
                     & (pc_wdata == stage_rec[DEPTH-1].pc_rdata)
                     & (stage_rec[DEPTH-1].pc_rdata != 32'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            order_q <= '0;
        end else if (rvfi_commit) begin
            order_q <= order_q + ORDER_W'(1);
        end
    end

    assign rvfi_order = order_q;

`ifdef RVFI_PERF_CNT_EN
    logic [31:0] commits_q;
    logic [31:0] bubbles_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            commits_q <= '0;
            bubbles_q <= '0;
        end else begin
            if (rvfi_commit && commits_q != '1) begin
                commits_q <= commits_q + 32'd1;
            end
            if (!rvfi_commit && bubbles_q != '1) begin
                bubbles_q <= bubbles_q + 32'd1;
            end
        end
    end

    assign perf_commits = commits_q;
    assign perf_bubbles = bubbles_q;
`else
    assign perf_commits = '0;
    assign perf_bubbles = '0;
`endif

    // Stall must be a run of ones from stage 0 upward; x & (x+1) is zero exactly for that shape.
    logic [DEPTH-1:0] stall_inc;
    assign stall_inc = stall + DEPTH'(1);

    a_stall_monotone: assert property (@(posedge clk) disable iff (rst) ((stall & stall_inc) == '0));

endmodule

// File: tb/tb_rvfi_shadow_pipe.sv
// Scoreboard bench for rvfi_shadow_pipe: directed vectors push expected commits,
// a negedge monitor pops and compares whenever rvfi_commit is seen.
module tb_rvfi_shadow_pipe;
    import rvfi_trace_pkg::*;

    localparam int DEPTH     = 3;
    localparam int MEM_STAGE = 1;
    localparam int ORDER_W   = 64;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] BEQ  = 32'h0000_0063;
    localparam logic [31:0] SW   = 32'h0011_2023;
    localparam logic [31:0] JAL0 = 32'h0000_006F;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pcw;
        logic [63:0] order;
        logic        halt;
        logic        trap;
        logic [31:0] rdw;
        logic [31:0] addr;
        logic [3:0]  wmask;
    } exp_t;

    logic               clk;
    logic               rst;
    logic               cap_valid;
    rec_t               cap_rec;
    logic [DEPTH-1:0]   stall;
    logic [DEPTH-1:0]   flush;
    logic               mem_valid;
    mem_t               mem_rec;
    logic [31:0]        fetch_pc;
    logic               wb_load_rf;
    logic [4:0]         wb_rd_addr;
    logic [31:0]        wb_rd_wdata;
    logic               rvfi_commit;
    pkt_t               rvfi_pkt;
    logic [ORDER_W-1:0] rvfi_order;
    logic               rvfi_halt;
    logic [31:0]        perf_commits;
    logic [31:0]        perf_bubbles;

    rvfi_shadow_pipe #(
        .DEPTH    (DEPTH),
        .MEM_STAGE(MEM_STAGE),
        .ORDER_W  (ORDER_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cap_valid   (cap_valid),
        .cap_rec     (cap_rec),
        .stall       (stall),
        .flush       (flush),
        .mem_valid   (mem_valid),
        .mem_rec     (mem_rec),
        .fetch_pc    (fetch_pc),
        .wb_load_rf  (wb_load_rf),
        .wb_rd_addr  (wb_rd_addr),
        .wb_rd_wdata (wb_rd_wdata),
        .rvfi_commit (rvfi_commit),
        .rvfi_pkt    (rvfi_pkt),
        .rvfi_order  (rvfi_order),
        .rvfi_halt   (rvfi_halt),
        .perf_commits(perf_commits),
        .perf_bubbles(perf_bubbles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        exp_q [$];
    exp_t        mon_e;
    logic [63:0] exp_order = 64'd0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cap(input logic [31:0] pc, input logic [31:0] inst);
        cap_valid          = 1'b1;
        cap_rec.pc_rdata   = pc;
        cap_rec.inst       = inst;
        cap_rec.rs1_addr   = 5'd1;
        cap_rec.rs2_addr   = 5'd2;
        cap_rec.rs1_rdata  = pc ^ 32'h5555_0000;
        cap_rec.rs2_rdata  = pc ^ 32'h0000_AAAA;
    endtask

    task automatic expect_commit(input logic [31:0] pc, input logic [31:0] pcw,
                                 input logic halt, input logic trap, input logic [31:0] rdw,
                                 input logic [31:0] addr, input logic [3:0] wmask);
        exp_t e;
        e.pc    = pc;
        e.pcw   = pcw;
        e.order = exp_order;
        e.halt  = halt;
        e.trap  = trap;
        e.rdw   = rdw;
        e.addr  = addr;
        e.wmask = wmask;
        exp_q.push_back(e);
        exp_order = exp_order + 64'd1;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            tick();
            n++;
        end
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        repeat (2) tick();
    endtask

    // Monitor: compare every retired packet against the head of the scoreboard.
    always @(negedge clk) begin
        if (rvfi_commit) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_commit: got commit of pc 0x%0h, expected no commit",
                         rvfi_pkt.rec.pc_rdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("pc_rdata", 64'(rvfi_pkt.rec.pc_rdata), 64'(mon_e.pc));
                check("pc_wdata", 64'(rvfi_pkt.pc_wdata),     64'(mon_e.pcw));
                check("order",    64'(rvfi_order),            mon_e.order);
                check("halt",     64'(rvfi_halt),             64'(mon_e.halt));
                check("trap",     64'(rvfi_pkt.trap),         64'(mon_e.trap));
                check("rd_wdata", 64'(rvfi_pkt.rd_wdata),     64'(mon_e.rdw));
                check("mem_addr", 64'(rvfi_pkt.mem.addr),     64'(mon_e.addr));
                check("mem_wmask",64'(rvfi_pkt.mem.wmask),    64'(mon_e.wmask));
            end
        end else begin
            check("halt_idle", 64'(rvfi_halt), 64'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench still running at time limit, expected completion");
        $fatal(1);
    end

    initial begin
        rst         = 1'b1;
        cap_valid   = 1'b0;
        cap_rec     = '0;
        stall       = '0;
        flush       = '0;
        mem_valid   = 1'b0;
        mem_rec     = '0;
        fetch_pc    = 32'd0;
        wb_load_rf  = 1'b1;
        wb_rd_addr  = 5'd5;
        wb_rd_wdata = 32'h0000_1234;
        repeat (3) tick();
        @(negedge clk);
        check("rst_commit", 64'(rvfi_commit), 64'd0);
        check("rst_order",  64'(rvfi_order),  64'd0);
        tick();
        rst = 1'b0;
        tick();

        // 1: straight line, first commit three cycles after first capture
        for (int k = 0; k < 4; k++) begin
            cap(32'h60 + 32'(4 * k), NOP);
            fetch_pc = 32'h64 + 32'(4 * k);
            expect_commit(32'h60 + 32'(4 * k), 32'h64 + 32'(4 * k), 1'b0, 1'b0,
                          32'h1234, 32'd0, 4'd0);
            @(negedge clk);
            check("t1_commit_timing", 64'(rvfi_commit), (k == 3) ? 64'd1 : 64'd0);
            tick();
        end
        cap_valid = 1'b0;
        drain("t1");

        // 2: stall[0] for two cycles opens two bubble cycles
        fetch_pc = 32'h110;
        cap(32'h100, NOP); expect_commit(32'h100, 32'h104, 1'b0, 1'b0, 32'h1234, 32'd0, 4'd0); tick();
        cap(32'h104, NOP); expect_commit(32'h104, 32'h108, 1'b0, 1'b0, 32'h1234, 32'd0, 4'd0); tick();
        cap(32'h108, NOP); expect_commit(32'h108, 32'h10C, 1'b0, 1'b0, 32'h1234, 32'd0, 4'd0);
        stall = 3'b001;
        tick();
        tick();
        stall = 3'b000;
        @(negedge clk);
        check("t2_bubble0", 64'(rvfi_commit), 64'd0);
        tick();
        cap(32'h10C, NOP); expect_commit(32'h10C, 32'h110, 1'b0, 1'b0, 32'h1234, 32'd0, 4'd0);
        @(negedge clk);
        check("t2_bubble1", 64'(rvfi_commit), 64'd0);
        tick();
        cap_valid = 1'b0;
        drain("t2");

        // 3: branch commits while its two younger records are flushed
        fetch_pc = 32'h200;
        cap(32'h180, BEQ); tick();
        cap(32'h184, NOP); tick();
        cap(32'h188, NOP); tick();
        cap_valid = 1'b0;
        flush     = 3'b011;
        expect_commit(32'h180, 32'h200, 1'b0, 1'b0, 32'h1234, 32'd0, 4'd0);
        tick();
        flush    = 3'b000;
        fetch_pc = 32'h204;
        cap(32'h200, NOP);
        expect_commit(32'h200, 32'h204, 1'b0, 1'b0, 32'h1234, 32'd0, 4'd0);
        tick();
        cap_valid = 1'b0;
        drain("t3");

        // 4: store held at the mem stage, then held again at commit
        fetch_pc = 32'h304;
        cap(32'h300, SW); tick();
        cap_valid = 1'b0;
        tick();
        mem_valid     = 1'b1;
        mem_rec       = '0;
        mem_rec.addr  = 32'h1000;
        mem_rec.wmask = 4'b0011;
        mem_rec.wdata = 32'h0000_CAFE;
        stall         = 3'b111;
        repeat (3) tick();
        stall = 3'b000;
        tick();
        mem_valid = 1'b0;
        mem_rec   = '0;
        stall     = 3'b111;
        expect_commit(32'h300, 32'h304, 1'b0, 1'b0, 32'h1234, 32'h1000, 4'b0011);
        @(negedge clk);
        check("t4_hold_no_commit", 64'(rvfi_commit), 64'd0);
        tick();
        stall = 3'b000;
        drain("t4");

        // 5: jump-to-self halts and x0 write data reads as zero; zero opcode traps
        fetch_pc    = 32'h80;
        wb_rd_addr  = 5'd0;
        wb_rd_wdata = 32'h0000_DEAD;
        cap(32'h80, JAL0);
        expect_commit(32'h80, 32'h80, 1'b1, 1'b0, 32'd0, 32'd0, 4'd0);
        tick();
        cap_valid = 1'b0;
        drain("t5_halt");
        wb_rd_addr  = 5'd5;
        wb_rd_wdata = 32'h0000_1234;
        fetch_pc    = 32'h94;
        cap(32'h90, 32'h0000_0000);
        expect_commit(32'h90, 32'h94, 1'b0, 1'b1, 32'h1234, 32'd0, 4'd0);
        tick();
        cap_valid = 1'b0;
        drain("t5_trap");

        // 6: reset with three records in flight drops them all
        fetch_pc = 32'h40C;
        for (int k = 0; k < 3; k++) begin
            cap(32'h400 + 32'(4 * k), NOP);
            tick();
        end
        cap_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        check("t6_commit_in_rst", 64'(rvfi_commit), 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t6_commit_after_rst", 64'(rvfi_commit), 64'd0);
        check("t6_order_after_rst",  64'(rvfi_order),  64'd0);
`ifdef RVFI_PERF_CNT_EN
        check("t6_perf_commits_rst", 64'(perf_commits), 64'd0);
        check("t6_perf_bubbles_rst", 64'(perf_bubbles), 64'd0);
`endif
        exp_order = 64'd0;
        tick();
        fetch_pc = 32'h504;
        cap(32'h500, NOP);
        expect_commit(32'h500, 32'h504, 1'b0, 1'b0, 32'h1234, 32'd0, 4'd0);
        tick();
        cap_valid = 1'b0;
        drain("t6");

`ifdef RVFI_PERF_CNT_EN
        check("perf_commits_end", 64'(perf_commits), 64'd1);
`else
        check("perf_commits_tied", 64'(perf_commits), 64'd0);
        check("perf_bubbles_tied", 64'(perf_bubbles), 64'd0);
`endif
        check("pending_expected", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
